// File: rtl/num_disp_pkg.sv
// Shared types and constants for the binary-to-BCD display path.
// Holds the converter FSM state enum, the BCD nine digit and a count-width helper.
package num_disp_pkg;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        FINISH
    } state_t;

    localparam logic [3:0] BCD_NINE = 4'h9;

    function automatic int cnt_width(input int bits);
        return $clog2(bits + 1);
    endfunction

endpackage

// File: rtl/num_to_bcd_if.sv
// Handshake bundle between the number-maker stage and the BCD converter.
// master: drives START/NUM, observes results; slave: the converter.
interface num_to_bcd_if #(
    parameter int BITS   = 16,
    parameter int DIGITS = 6
);

    logic                        START;
    logic [BITS-1:0]             NUM;
    logic [4*(DIGITS-1)-1:0]     BCD;
    logic                        NEG;
    logic                        OVF;
    logic                        BUSY;
    logic                        DONE;

    modport master (
        output START, NUM,
        input  BCD, NEG, OVF, BUSY, DONE
    );

    modport slave (
        input  START, NUM,
        output BCD, NEG, OVF, BUSY, DONE
    );

endinterface

// File: rtl/bcd_digit_adj.sv
// Double-dabble digit correction: adds 3 to a BCD digit that is >= 5.
// Ports: digit (current 4-bit digit), adjusted (corrected digit).
module bcd_digit_adj (
    input  logic [3:0] digit,
    output logic [3:0] adjusted
);

    always_comb begin
        adjusted = digit;
        if (digit >= 4'd5) begin
            adjusted = digit + 4'd3;
        end
    end

endmodule

// File: rtl/num_to_bcd.sv
// Sequential two's-complement to sign + packed BCD converter (double dabble).
// Ports: CLK, RST (sync, active high), bus (slave: START/NUM in, BCD/NEG/OVF/BUSY/DONE out).
module num_to_bcd
    import num_disp_pkg::*;
#(
    parameter int BITS   = 16,
    parameter int DIGITS = 6
) (
    input  logic       CLK,
    input  logic       RST,
    num_to_bcd_if.slave bus
);

    localparam int ND = DIGITS - 1;
    localparam int DW = 4 * ND;
    localparam int CW = cnt_width(BITS);
    localparam logic [CW-1:0] LAST = CW'(BITS - 1);

    state_t state;
    state_t state_nxt;

    logic            sign_q;
    logic            nz_q;
    logic            sticky_q;
    logic [BITS-1:0] mag_q;
    logic [DW-1:0]   dig_q;
    logic [CW-1:0]   cnt_q;

    logic [DW-1:0]   bcd_q;
    logic            neg_q;
    logic            ovf_q;
    logic            done_q;

    logic [DW-1:0]      dig_adj;
    logic [DW+BITS:0]   shifted;
    logic [BITS-1:0]    mag_in;
    logic [DW-1:0]      nines;

    for (genvar g = 0; g < ND; g++) begin : g_adj
        bcd_digit_adj u_adj (
            .digit    (dig_q[4*g +: 4]),
            .adjusted (dig_adj[4*g +: 4])
        );
    end

    // Top bit is the bit leaving the most significant digit.
    assign shifted = {dig_adj, mag_q, 1'b0};

    // -2^(BITS-1) negates to itself, which is the correct unsigned magnitude.
    assign mag_in = bus.NUM[BITS-1] ? (~bus.NUM + BITS'(1)) : bus.NUM;

    assign nines = {ND{BCD_NINE}};

    always_comb begin
        state_nxt = state;
        unique case (state)
            IDLE: begin
                if (bus.START) begin
                    state_nxt = SHIFT;
                end
            end
            SHIFT: begin
                if (cnt_q == LAST) begin
                    state_nxt = FINISH;
                end
            end
            FINISH: begin
                state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            state    <= IDLE;
            sign_q   <= 1'b0;
            nz_q     <= 1'b0;
            sticky_q <= 1'b0;
            mag_q    <= '0;
            dig_q    <= '0;
            cnt_q    <= '0;
            bcd_q    <= '0;
            neg_q    <= 1'b0;
            ovf_q    <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state  <= state_nxt;
            done_q <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (bus.START) begin
                        sign_q   <= bus.NUM[BITS-1];
                        nz_q     <= |bus.NUM;
                        mag_q    <= mag_in;
                        dig_q    <= '0;
                        sticky_q <= 1'b0;
                        cnt_q    <= '0;
                    end
                end
                SHIFT: begin
                    dig_q    <= shifted[DW+BITS-1:BITS];
                    mag_q    <= shifted[BITS-1:0];
                    sticky_q <= sticky_q | shifted[DW+BITS];
                    cnt_q    <= cnt_q + CW'(1);
                end
                FINISH: begin
                    bcd_q  <= sticky_q ? nines : dig_q;
                    neg_q  <= sign_q & nz_q;
                    ovf_q  <= sticky_q;
                    done_q <= 1'b1;
                end
                default: begin
                end
            endcase
        end
    end

    assign bus.BCD  = bcd_q;
    assign bus.NEG  = neg_q;
    assign bus.OVF  = ovf_q;
    assign bus.DONE = done_q;
    assign bus.BUSY = (state != IDLE);

endmodule

// File: tb/tb_num_to_bcd.sv
// Self-checking bench for num_to_bcd: default and DIGITS=4 instances,
// table-driven conversions plus hand-written handshake/reset sequences.
module tb_num_to_bcd;

    logic CLK = 1'b0;
    logic RST;

    always #5 CLK = ~CLK;

    num_to_bcd_if #(.BITS(16), .DIGITS(6)) bus6 ();
    num_to_bcd_if #(.BITS(16), .DIGITS(4)) bus4 ();

    num_to_bcd #(.BITS(16), .DIGITS(6)) u_dut6 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus6.slave)
    );

    num_to_bcd #(.BITS(16), .DIGITS(4)) u_dut4 (
        .CLK (CLK),
        .RST (RST),
        .bus (bus4.slave)
    );

    typedef struct {
        bit          d4;
        logic [15:0] num;
        logic [19:0] bcd;
        bit          neg;
        bit          ovf;
    } vec_t;

    vec_t vecs[10];

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [19:0] get_bcd(input bit d4);
        return d4 ? {8'h00, bus4.BCD} : bus6.BCD;
    endfunction

    // Pulse START for one edge, then count cycles until DONE (bounded).
    task automatic conv(input bit d4, input logic [15:0] n,
                        output int lat, output int busy_cnt);
        @(posedge CLK); #1;
        if (d4) begin
            bus4.START = 1'b1;
            bus4.NUM   = n;
        end else begin
            bus6.START = 1'b1;
            bus6.NUM   = n;
        end
        @(posedge CLK); #1;
        bus4.START = 1'b0;
        bus6.START = 1'b0;
        lat      = -1;
        busy_cnt = 0;
        for (int k = 1; k <= 40; k++) begin
            if (d4 ? bus4.BUSY : bus6.BUSY) busy_cnt++;
            @(posedge CLK); #1;
            if (d4 ? bus4.DONE : bus6.DONE) begin
                lat = k;
                break;
            end
        end
    endtask

    initial begin
        int lat;
        int bcnt;
        int dones;
        int bad;

        vecs[0] = '{0, 16'd12345, 20'h12345, 0, 0};
        vecs[1] = '{0, 16'hFFFF,  20'h00001, 1, 0};
        vecs[2] = '{0, 16'h8000,  20'h32768, 1, 0};
        vecs[3] = '{0, 16'h7FFF,  20'h32767, 0, 0};
        vecs[4] = '{0, 16'h0000,  20'h00000, 0, 0};
        vecs[5] = '{0, 16'd42,    20'h00042, 0, 0};
        vecs[6] = '{1, 16'd999,   20'h00999, 0, 0};
        vecs[7] = '{1, 16'd1000,  20'h00999, 0, 1};
        vecs[8] = '{1, 16'hFC18,  20'h00999, 1, 1};
        vecs[9] = '{1, 16'd0,     20'h00000, 0, 0};

        RST        = 1'b1;
        bus6.START = 1'b0;
        bus6.NUM   = '0;
        bus4.START = 1'b0;
        bus4.NUM   = '0;
        repeat (3) @(posedge CLK);
        #1;
        RST = 1'b0;

        chk("reset6", {bus6.BCD, bus6.NEG, bus6.OVF, bus6.BUSY, bus6.DONE}, 0);
        chk("reset4", {bus4.BCD, bus4.NEG, bus4.OVF, bus4.BUSY, bus4.DONE}, 0);

        for (int i = 0; i < 10; i++) begin
            conv(vecs[i].d4, vecs[i].num, lat, bcnt);
            chk($sformatf("v%0d_lat", i), lat, 17);
            chk($sformatf("v%0d_busy", i), bcnt, 17);
            chk($sformatf("v%0d_bcd", i), get_bcd(vecs[i].d4), vecs[i].bcd);
            chk($sformatf("v%0d_neg", i),
                vecs[i].d4 ? bus4.NEG : bus6.NEG, vecs[i].neg);
            chk($sformatf("v%0d_ovf", i),
                vecs[i].d4 ? bus4.OVF : bus6.OVF, vecs[i].ovf);
            @(posedge CLK); #1;
            chk($sformatf("v%0d_pulse", i),
                vecs[i].d4 ? bus4.DONE : bus6.DONE, 0);
        end

        // START during SHIFT and during FINISH must be ignored.
        @(posedge CLK); #1;
        bus6.START = 1'b1;
        bus6.NUM   = 16'd12345;
        @(posedge CLK); #1;
        bus6.START = 1'b0;
        bus6.NUM   = 16'd1;
        dones = 0;
        for (int k = 1; k <= 40; k++) begin
            bus6.START = (k == 5 || k == 17);
            if (k == 17) chk("fin_busy", bus6.BUSY, 1);
            @(posedge CLK); #1;
            if (bus6.DONE) dones++;
        end
        bus6.START = 1'b0;
        chk("ign_dones", dones, 1);
        chk("ign_bcd", bus6.BCD, 20'h12345);
        conv(0, 16'd1, lat, bcnt);
        chk("after_ign_lat", lat, 17);
        chk("after_ign_bcd", bus6.BCD, 20'h00001);

        // Outputs hold while NUM wanders without START.
        conv(0, 16'd42, lat, bcnt);
        chk("hold_pre", bus6.BCD, 20'h00042);
        bad = 0;
        for (int k = 0; k < 50; k++) begin
            bus6.NUM = 16'($urandom);
            @(posedge CLK); #1;
            if (bus6.BCD !== 20'h00042 || bus6.NEG !== 1'b0 ||
                bus6.OVF !== 1'b0 || bus6.DONE !== 1'b0 ||
                bus6.BUSY !== 1'b0) bad++;
        end
        chk("hold_50", bad, 0);

        // Reset mid-conversion.
        conv(0, 16'hFFFB, lat, bcnt);
        chk("pre_rst_bcd", bus6.BCD, 20'h00005);
        chk("pre_rst_neg", bus6.NEG, 1);
        @(posedge CLK); #1;
        bus6.START = 1'b1;
        bus6.NUM   = 16'd500;
        @(posedge CLK); #1;
        bus6.START = 1'b0;
        for (int k = 1; k <= 7; k++) begin
            @(posedge CLK); #1;
        end
        chk("mid_hold", {bus6.BCD, bus6.NEG}, {20'h00005, 1'b1});
        RST = 1'b1;
        @(posedge CLK); #1;
        RST = 1'b0;
        chk("rst_out", {bus6.BCD, bus6.NEG, bus6.OVF, bus6.BUSY, bus6.DONE}, 0);
        dones = 0;
        for (int k = 0; k < 25; k++) begin
            @(posedge CLK); #1;
            if (bus6.DONE) dones++;
        end
        chk("rst_no_done", dones, 0);
        conv(0, 16'd500, lat, bcnt);
        chk("post_rst_lat", lat, 17);
        chk("post_rst_bcd", bus6.BCD, 20'h00500);
        chk("post_rst_neg", bus6.NEG, 0);

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/num_to_bcd.md
Name: num_to_bcd

Overview:
Sequential binary-to-BCD converter that sits directly downstream of the number-maker stage. It takes that stage's BITS-wide two's-complement value and produces a sign flag plus DIGITS-1 packed BCD magnitude digits for the 7-segment display driver. The leftmost display position carries the sign. Conversion uses shift-and-add-3 (double dabble), one bit per clock, with a START/BUSY/DONE handshake.

Parameters:
BITS, 16, width of input NUM (two's complement).
DIGITS, 6, display positions: one sign position plus DIGITS-1 magnitude digits.

Ports:
CLK  input  1  system clock, rising edge.
RST  input  1  synchronous, active-high reset.
START  input  1  conversion request; sampled only in IDLE.
NUM  input  BITS  two's-complement value to convert.
BCD  output  4*(DIGITS-1)  packed magnitude digits; digit 0 (LSD) in bits [3:0].
NEG  output  1  1 when the converted NUM was negative.
OVF  output  1  1 when the magnitude exceeds 10^(DIGITS-1)-1.
BUSY  output  1  high in any state other than IDLE.
DONE  output  1  one-cycle pulse when BCD, NEG and OVF update.

Behaviour:
- One clock domain. Reset is synchronous and active-high, on CLK/RST.
- Reset state: IDLE. BCD=0, NEG=0, OVF=0, BUSY=0, DONE=0. Internal shift and count registers are cleared.
- States: IDLE, SHIFT, FINISH.
- IDLE -> SHIFT when START=1. On that edge:
  - capture sign = NUM[BITS-1];
  - capture mag = |NUM| as a BITS-bit unsigned value (for -2^(BITS-1) this gives 2^(BITS-1));
  - clear the working BCD register, the overflow sticky bit and the count.
- SHIFT, one cycle per bit:
  - every working digit >= 5 gets +3;
  - then {digits, mag} shifts left by 1;
  - any 1 shifted out of the top digit sets the overflow sticky bit.
  - After BITS shift cycles, go to FINISH.
- FINISH (one cycle):
  - BCD <= working digits, or all digits = 9 if the sticky bit is set (saturate);
  - NEG <= sign, except NEG=0 when the magnitude is 0;
  - OVF <= sticky bit; DONE=1;
  - next state IDLE.
- Latency: START sampled at edge 0, DONE high for the cycle after edge BITS+1. Default: 17 cycles after the START edge.
- Throughput: one conversion per BITS+2 cycles.
- Output holding: BCD, NEG and OVF are registered and hold their values until the next FINISH. They never show intermediate values.
- START while BUSY=1 (including the FINISH cycle) is ignored and not queued.
- NUM is sampled only on the accepting edge. Changes during SHIFT have no effect.
- RST mid-conversion: return to IDLE immediately and clear all outputs to their reset values. No DONE pulse is produced.
- Count width: clog2(BITS+1).
- Working register: 4*(DIGITS-1) digit bits plus BITS magnitude bits.
- Valid for BITS >= 2 and DIGITS >= 2. With the defaults, OVF can never be set (max magnitude 32768 fits in 5 digits).

Decomposition:
- Package num_disp_pkg holds:
  - the state enum (IDLE, SHIFT, FINISH);
  - a BCD_NINE constant (4'h9);
  - a function returning the count width from BITS.
- Sub-module bcd_digit_adj: 4-bit combinational add-3-if->=5. It is instantiated DIGITS-1 times in a generate loop.
- Everything else is in num_to_bcd.

Test Plan:
- Defaults, NUM=16'd12345, START pulse -> DONE exactly 17 cycles later; BCD=20'h12345, NEG=0, OVF=0; BUSY high for cycles 1..17.
- NUM=16'hFFFF (-1) -> BCD=20'h00001, NEG=1. NUM=16'h8000 -> BCD=20'h32768, NEG=1. NUM=16'h7FFF -> BCD=20'h32767, NEG=0. NUM=0 -> BCD=0, NEG=0.
- DIGITS=4 override: NUM=16'd999 -> BCD=12'h999, OVF=0. NUM=16'd1000 -> BCD=12'h999, OVF=1. NUM=-16'd1000 -> OVF=1, NEG=1.
- Convert 12345, then pulse START with NUM=1 at cycle 5 and in the FINISH cycle -> both ignored, one DONE, BCD=20'h12345. The next START in IDLE with NUM=1 -> BCD=20'h00001.
- After a completed conversion (BCD=20'h00042), change NUM without START -> outputs unchanged for 50 cycles.
- START with NUM=16'd500, RST at cycle 8 -> no DONE; BCD=0, NEG=0, OVF=0, BUSY=0 next cycle. A new START then converts normally.
